booth_mult_r4: RTL
==================

# booth_mult_r4

Parametrised, sequential radix-4 Booth multiplier. It takes two WIDTH-bit operands under a start/done handshake, supports signed and unsigned operation, and returns a registered 2·WIDTH-bit product. It replaces the fixed 32-bit multiplier as the MUL/DIV-unit multiply path in the datapath and retires two multiplier bits per clock.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 4.
- clk  in  1  clock, rising-edge
- clr  in  1  asynchronous active-high reset
- start  in  1  request; sampled only when not busy
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; product is valid in the same cycle
- product  out  2·WIDTH  result; holds until the next done

## Operation
- States:
  - IDLE: on start, go to CALC.
  - CALC: stay for N = WIDTH/2+1 iterations, then go to DONE.
  - DONE: exactly one cycle, then IDLE. A start seen in DONE is accepted and goes straight to CALC.
- Operand capture:
  - a and b are extended to WIDTH+2 bits: sign-extended if signed_mode, zero-extended otherwise.
  - This extension makes a single recoding scheme serve both modes.
- Iteration i (0..N-1):
  - Recode the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
  - 000 or 111 → 0; 001 or 010 → +A; 011 → +2A; 100 → −2A; 101 or 110 → −A.
- Accumulator:
  - Width is 2·WIDTH+4 bits.
  - Each iteration adds the selected multiple, aligned at bit 2i (or uses an equivalent shift-right-arithmetic-by-2 form).
- Result: product takes the low 2·WIDTH bits of the accumulator. This is exact in both modes; no overflow is possible.
- start while busy: ignored. No queueing, and the captured operands are not disturbed.
- Operand stability: a, b and signed_mode may change freely after the start cycle.
- clr (any time, including mid-CALC):
  - State goes to IDLE immediately.
  - busy = 0, done = 0, product = 0; accumulator and operand registers are cleared.
  - The operation in flight is abandoned and never produces done.

## Timing
- Reset values: busy 0, done 0, product 0.
- Start accepted at rising edge k:
  - busy = 1 during cycles k+1 … k+N.
  - done = 1 and product valid in cycle k+N+1; busy = 0 in that cycle.
- Latency from start to done is N+1 cycles: 18 for WIDTH = 32.
- Throughput: back-to-back start in the DONE cycle gives one result per N+1 cycles.
- done never asserts for two consecutive cycles.

## Configuration
- Macro: BOOTH_MULT_R4_EARLY_TERM_EN.
- Defined:
  - CALC exits early when every remaining multiplier triplet would recode to 0, i.e. the unprocessed bits of b, together with the last-examined bit, are all 0s or all 1s.
  - Latency ranges from 2 to N+1 cycles. Example: b = 0 finishes after 1 CALC cycle, so done appears at k+2.
  - Results are identical to the non-early-termination build.
- Undefined:
  - Latency is fixed at N+1 cycles.
  - No early-termination comparator logic is present.

## Structure
- Shared package booth_pkg:
  - state enum {IDLE, CALC, DONE}
  - recoded digit type {ZERO, POS1, POS2, NEG1, NEG2}
  - constant function computing N from WIDTH
- Sub-module booth_r4_recoder:
  - Combinational.
  - Inputs: 3-bit triplet and the extended multiplicand.
  - Output: signed partial product of width WIDTH+3.
  - Instantiated once and reused every iteration.

## Test plan
- WIDTH=32, signed, a=3, b=5 → product=15; done at exactly k+18 (fixed-latency build).
- Signed, a=−7, b=6 → product=0xFFFF_FFFF_FFFF_FFD6. Signed, a=0x8000_0000, b=0x8000_0000 → product=0x4000_0000_0000_0000.
- Unsigned, a=b=0xFFFF_FFFF → product=0xFFFF_FFFE_0000_0001. The same operands in signed mode → product=1.
- Start held high with a changing every cycle during CALC → a single result for the first operands only; the next start is accepted in the DONE cycle.
- clr pulsed at CALC iteration 5 → busy, done and product are 0 immediately; no done follows; a new start afterwards gives the correct result.
- Random 10k vectors at WIDTH ∈ {4, 16, 32}, both modes, with and without BOOTH_MULT_R4_EARLY_TERM_EN → every product matches the reference model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// recoded digit type, iteration count and triplet recoding.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

  // One iteration per pair of extended multiplier bits (WIDTH+2 bits).
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

  function automatic digit_t booth_recode(input logic [2:0] triplet);
    digit_t d;
    case (triplet)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: turns a multiplier triplet and the
// extended multiplicand into one signed partial product.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] a_x1;
  logic [WIDTH+2:0] a_x2;

  assign a_x1 = {a_ext[WIDTH+1], a_ext};
  assign a_x2 = {a_ext, 1'b0};

  always_comb begin
    pp = '0;
    case (booth_recode(triplet))
      POS1:    pp = a_x1;
      POS2:    pp = a_x2;
      NEG1:    pp = -a_x1;
      NEG2:    pp = -a_x2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Optional early termination: define BOOTH_MULT_R4_EARLY_TERM_EN.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N     = booth_iters(WIDTH);
  localparam int IW    = $clog2(N);
  localparam int EW    = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;

  state_t               state_q;
  logic [EW-1:0]        a_q, b_q;
  logic                 prev_q;
  logic [IW-1:0]        iter_q;
  logic [ACC_W-1:0]     acc_q;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [EW-1:0]        a_ext_d, b_ext_d, b_d;
  logic [EW:0]          pp;
  logic [ACC_W-1:0]     pp_ext, acc_d;
  logic                 last_iter;

  booth_r4_recoder #(.WIDTH(WIDTH)) u_recoder (
    .triplet ({b_q[1:0], prev_q}),
    .a_ext   (a_q),
    .pp      (pp)
  );

  always_comb begin
    a_ext_d = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_ext_d = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    pp_ext  = {{(ACC_W-EW-1){pp[EW]}}, pp};
    acc_d   = acc_q + (pp_ext << {iter_q, 1'b0});
    // Arithmetic shift keeps the padding consistent with the sign extension.
    b_d     = {{2{b_q[EW-1]}}, b_q[EW-1:2]};
  end

`ifdef BOOTH_MULT_R4_EARLY_TERM_EN
  // Remaining bits plus the last-examined bit all equal: every later digit is 0.
  assign last_iter = (iter_q == IW'(N-1)) || (&b_q[EW-1:1]) || ~(|b_q[EW-1:1]);
`else
  assign last_iter = (iter_q == IW'(N-1));
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      prev_q    <= 1'b0;
      iter_q    <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        CALC: begin
          acc_q  <= acc_d;
          b_q    <= b_d;
          prev_q <= b_q[1];
          iter_q <= iter_q + 1'b1;
          if (last_iter) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= acc_d[2*WIDTH-1:0];
          end
        end
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            a_q     <= a_ext_d;
            b_q     <= b_ext_d;
            prev_q  <= 1'b0;
            iter_q  <= '0;
            acc_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
